// File: rtl/mii_tx_framer.sv
// MII transmit framer: wraps a byte stream with preamble/SFD, pads short frames,
// appends the Ethernet FCS and enforces the inter-frame gap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line quiet, waiting for tx_mac_valid
// PREAMBLE | 15 nibbles of 4'h5
// SFD      | nibble 4'hD, first byte accepted here
// DATA     | payload bytes, low nibble then high nibble
// PAD      | zero bytes until MIN_PAYLOAD reached
// FCS      | 8 nibbles of complemented CRC-32, LS nibble first
// IFG      | line quiet for IFG_NIBBLES cycles
module mii_tx_framer #(
  parameter int IFG_NIBBLES = 24,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_mac_data,
  input  logic       tx_mac_valid,
  input  logic       tx_mac_last,
  output logic       tx_mac_ready,
  output logic       phy_tx_en,
  output logic [3:0] phy_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam int TMAX = (IFG_NIBBLES > 15) ? IFG_NIBBLES : 15;
  localparam int TW   = $clog2(TMAX + 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tim_q, tim_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic          hi_q, hi_d;
  logic          last_q, last_d;
  logic          ready_q, ready_d;
  logic          en_q, en_d;
  logic [3:0]    txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          urun_q, urun_d;
  logic          consume, take, pad, fcs, abort;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    tim_d    = tim_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    hi_nib_d = hi_nib_q;
    hi_d     = hi_q;
    last_d   = last_q;
    take     = 1'b0;
    pad      = 1'b0;
    fcs      = 1'b0;
    abort    = 1'b0;
    consume  = tx_mac_valid && ready_q;

    case (state_q)
      S_IDLE: if (tx_mac_valid) begin
        state_d = S_PRE;
        tim_d   = TW'(14);
      end
      S_PRE: if (tim_q == '0) begin
        state_d = S_SFD;
        crc_d   = 32'hFFFFFFFF;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else begin
        tim_d = tim_q - 1'b1;
      end
      S_SFD: if (consume) take = 1'b1; else abort = 1'b1;
      S_DATA: begin
        if (!hi_q)                             hi_d = 1'b1;
        else if (last_q && cnt_q < 11'(MIN_PAYLOAD)) pad = 1'b1;
        else if (last_q)                       fcs = 1'b1;
        else if (consume)                      take = 1'b1;
        else                                   abort = 1'b1;
      end
      S_PAD: begin
        if (!hi_q)                          hi_d = 1'b1;
        else if (cnt_q >= 11'(MIN_PAYLOAD)) fcs = 1'b1;
        else                                pad = 1'b1;
      end
      S_FCS: if (tim_q == '0) begin
        state_d = S_IFG;
        tim_d   = TW'(IFG_NIBBLES - 1);
      end else begin
        tim_d = tim_q - 1'b1;
        crc_d = {4'h0, crc_q[31:4]};
      end
      S_IFG: if (tim_q == '0) state_d = S_IDLE; else tim_d = tim_q - 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (take || pad) begin
      hi_d  = 1'b0;
      cnt_d = (cnt_q == 11'd2047) ? cnt_q : cnt_q + 11'd1;
    end
    if (take) begin
      state_d  = S_DATA;
      hi_nib_d = tx_mac_data[7:4];
      last_d   = tx_mac_last;
      crc_d    = crc_byte(crc_q, tx_mac_data);
    end
    if (pad) begin
      state_d  = S_PAD;
      hi_nib_d = 4'h0;
      crc_d    = crc_byte(crc_q, 8'h00);
    end
    // FCS nibbles are taken from the low end of crc_q, which shifts down each cycle
    if (fcs) begin
      state_d = S_FCS;
      tim_d   = TW'(7);
      crc_d   = {4'h0, crc_q[31:4]};
    end
    if (abort) begin
      state_d = S_IFG;
      tim_d   = TW'(IFG_NIBBLES - 1);
    end

    case (state_d)
      S_PRE:   txd_d = 4'h5;
      S_SFD:   txd_d = 4'hD;
      S_DATA:  txd_d = take ? tx_mac_data[3:0] : hi_nib_q;
      S_FCS:   txd_d = ~crc_q[3:0];
      default: txd_d = 4'h0;
    endcase
    en_d    = (state_d == S_PRE) || (state_d == S_SFD) || (state_d == S_DATA) ||
              (state_d == S_PAD) || (state_d == S_FCS);
    ready_d = (state_d == S_SFD) || ((state_d == S_DATA) && hi_d && !last_d);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_FCS) && (tim_q == TW'(1));
    urun_d  = abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tim_q    <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      hi_nib_q <= '0;
      hi_q     <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      en_q     <= 1'b0;
      txd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tim_q    <= tim_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      hi_nib_q <= hi_nib_d;
      hi_q     <= hi_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      urun_q   <= urun_d;
    end
  end

  assign tx_mac_ready = ready_q;
  assign phy_tx_en    = en_q;
  assign phy_txd      = txd_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign tx_underrun  = urun_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: logs the MII line per cycle, then decodes
// frames and checks lengths, preamble, payload/pad bytes and the CRC residue.
`timescale 1ns/1ps
module tb_mii_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_mac_data = 8'h00;
  logic       tx_mac_valid = 1'b0;
  logic       tx_mac_last = 1'b0;
  logic       tx_mac_ready, phy_tx_en, tx_busy, tx_done, tx_underrun;
  logic [3:0] phy_txd;

  always #5 clk = ~clk;

  mii_tx_framer dut (
    .clk(clk), .reset(reset),
    .tx_mac_data(tx_mac_data), .tx_mac_valid(tx_mac_valid), .tx_mac_last(tx_mac_last),
    .tx_mac_ready(tx_mac_ready), .phy_tx_en(phy_tx_en), .phy_txd(phy_txd),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src_d[$];
  logic       src_l[$];
  int         sp;

  logic       en_log[0:4095];
  logic [3:0] txd_log[0:4095];
  logic       busy_log[0:4095];
  int         lc, n_done, n_urun, urun_at, timed_out;
  int         run_st[4], run_len[4], nr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_res(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t mk_frame(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'((i * 37 + seed) % 256));
    return q;
  endfunction

  function automatic bq_t padded(input bq_t b);
    bq_t q;
    q = b;
    while (q.size() < 60) q.push_back(8'h00);
    return q;
  endfunction

  task automatic clear_src();
    src_d.delete();
    src_l.delete();
    sp = 0;
  endtask

  task automatic push_frame(input bq_t b);
    foreach (b[i]) begin
      src_d.push_back(b[i]);
      src_l.push_back(i == b.size() - 1);
    end
  endtask

  // Drives the byte source with a valid/ready handshake and logs the line.
  // tx_mac_last is held high whenever valid is low.
  task automatic run(input int stop_en);
    int  idle_cnt, en_seen, cyc;
    logic fire;
    idle_cnt = 0; en_seen = 0; cyc = 0;
    lc = 0; n_done = 0; n_urun = 0; urun_at = -1; timed_out = 0;
    while (1) begin
      if (sp < src_d.size()) begin
        tx_mac_valid = 1'b1; tx_mac_data = src_d[sp]; tx_mac_last = src_l[sp];
      end else begin
        tx_mac_valid = 1'b0; tx_mac_data = 8'h00; tx_mac_last = 1'b1;
      end
      fire = tx_mac_valid && tx_mac_ready;
      @(posedge clk); #1;
      if (fire) sp++;
      if (lc < 4096) begin
        en_log[lc] = phy_tx_en; txd_log[lc] = phy_txd; busy_log[lc] = tx_busy;
      end
      if (tx_done) n_done++;
      if (tx_underrun) begin n_urun++; if (urun_at < 0) urun_at = lc; end
      lc++;
      if (phy_tx_en) en_seen++;
      if (stop_en > 0 && en_seen >= stop_en) break;
      idle_cnt = (sp == src_d.size() && !tx_busy) ? idle_cnt + 1 : 0;
      if (idle_cnt >= 3) break;
      cyc++;
      if (cyc > 6000 || lc >= 4096) begin timed_out = 1; break; end
    end
    tx_mac_valid = 1'b0; tx_mac_last = 1'b0;
    chk("run_timeout", 32'(timed_out), 0);
  endtask

  task automatic analyze(input int exp_runs);
    nr = 0;
    for (int i = 0; i < lc; i++) begin
      if (en_log[i] && (i == 0 || !en_log[i-1])) begin
        if (nr < 4) begin run_st[nr] = i; run_len[nr] = 0; end
        nr++;
      end
      if (en_log[i] && nr > 0 && nr <= 4) run_len[nr-1]++;
    end
    chk("num_frames", 32'(nr), 32'(exp_runs));
  endtask

  task automatic chk_frame(input string tag, input int r, input bq_t exp);
    int  st, len, nb, bad;
    bq_t got;
    st = run_st[r]; len = run_len[r];
    chk({tag, "_tx_en_len"}, 32'(len), 32'(16 + 2 * exp.size() + 8));
    bad = 0;
    for (int i = 0; i < 15; i++) if (txd_log[st+i] !== 4'h5) bad++;
    if (txd_log[st+15] !== 4'hD) bad++;
    chk({tag, "_preamble_sfd"}, 32'(bad), 0);
    nb = (len - 16) / 2;
    for (int i = 0; i < nb; i++) got.push_back({txd_log[st+17+2*i], txd_log[st+16+2*i]});
    bad = 0;
    foreach (exp[i]) if (i >= nb - 4 || got[i] !== exp[i]) bad++;
    chk({tag, "_payload"}, 32'(bad), 0);
    chk({tag, "_crc_residue"}, crc_res(got), 32'hDEBB20E3);
  endtask

  initial begin
    bq_t f, e;
    int  cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", 32'(phy_tx_en), 0);
    chk("rst_txd", 32'(phy_txd), 0);
    chk("rst_ready", 32'(tx_mac_ready), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_underrun", 32'(tx_underrun), 0);
    reset = 1'b0;

    // last without valid must not start a frame
    tx_mac_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("last_no_valid_busy", 32'(tx_busy), 0);
    tx_mac_last = 1'b0;

    // 64-byte frame
    clear_src();
    f = mk_frame(64, 5);
    push_frame(f);
    run(0);
    analyze(1);
    chk_frame("f64", 0, f);
    chk("f64_done", 32'(n_done), 1);
    chk("f64_underrun", 32'(n_urun), 0);

    // 1-byte frame, padded
    clear_src();
    f = '{8'hA7};
    push_frame(f);
    run(0);
    analyze(1);
    chk_frame("f1", 0, padded(f));
    chk("f1_lo_nib", 32'(txd_log[run_st[0]+16]), 32'h7);
    chk("f1_hi_nib", 32'(txd_log[run_st[0]+17]), 32'hA);
    chk("f1_done", 32'(n_done), 1);

    // underrun: only 10 bytes of a 64-byte frame ever presented
    clear_src();
    f = mk_frame(10, 11);
    foreach (f[i]) begin src_d.push_back(f[i]); src_l.push_back(1'b0); end
    run(0);
    analyze(1);
    chk("urun_pulses", 32'(n_urun), 1);
    chk("urun_done", 32'(n_done), 0);
    chk("urun_tx_en_len", 32'(run_len[0]), 36);
    chk("urun_pulse_pos", 32'(urun_at), 32'(run_st[0] + 36));
    cnt = 0;
    for (int i = urun_at; i >= 0 && i < lc && busy_log[i]; i++) cnt++;
    chk("urun_ifg_len", 32'(cnt), 24);

    // back-to-back 60-byte frames, valid held high
    clear_src();
    f = mk_frame(60, 1);
    e = mk_frame(60, 99);
    push_frame(f);
    push_frame(e);
    run(0);
    analyze(2);
    chk_frame("b2b_a", 0, f);
    chk_frame("b2b_b", 1, e);
    chk("b2b_gap", 32'(run_st[1] - (run_st[0] + run_len[0])), 25);
    chk("b2b_done", 32'(n_done), 2);

    // reset in the middle of PAD
    clear_src();
    f = '{8'h3C};
    push_frame(f);
    run(30);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tx_en", 32'(phy_tx_en), 0);
    chk("midrst_txd", 32'(phy_txd), 0);
    chk("midrst_ready", 32'(tx_mac_ready), 0);
    chk("midrst_busy", 32'(tx_busy), 0);
    chk("midrst_done", 32'(tx_done), 0);
    reset = 1'b0;
    clear_src();
    f = mk_frame(60, 42);
    push_frame(f);
    run(0);
    analyze(1);
    chk_frame("after_rst", 0, f);

    // maximum-size frame
    clear_src();
    f = mk_frame(1514, 17);
    push_frame(f);
    run(0);
    analyze(1);
    chk_frame("f1514", 0, f);
    chk("f1514_done", 32'(n_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
